// File: rtl/clock_control_logic_muxn.sv
// Clock-mux control sequencer.
// Selects one of NUM_PARENTS parent clocks and requests it. Drives the per-input
// enable of a glitch-free mux hard macro with break-before-make. Reports child
// clock status as a Moore decode of the registered state and current index.
// Ports:
//   clock, reset                 : sole clock, synchronous active-high reset
//   sel / sel_valid / sel_ready  : parent selection handshake
//   parent_*                     : per-parent clock request and status
//   child_*                      : downstream request and status
//   async_enable / _ack          : mux macro enables and their asynchronous acks
//   err_bad_sel / err_timeout    : rejected-select pulse, sticky wait timeout
module clock_control_logic_muxn #(
  parameter int unsigned NUM_PARENTS    = 4,
  parameter int unsigned DEFAULT_SEL    = 0,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned SEL_W = (NUM_PARENTS > 2) ? $clog2(NUM_PARENTS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic [NUM_PARENTS-1:0] parent_request,
  input  logic [NUM_PARENTS-1:0] parent_ready,
  input  logic [NUM_PARENTS-1:0] parent_silent,
  input  logic [NUM_PARENTS-1:0] parent_starting,
  input  logic [NUM_PARENTS-1:0] parent_stopping,
  input  logic                   child_request,
  output logic                   child_ready,
  output logic                   child_silent,
  output logic                   child_starting,
  output logic                   child_stopping,
  output logic [NUM_PARENTS-1:0] async_enable,
  input  logic [NUM_PARENTS-1:0] async_enable_ack,
  output logic                   err_bad_sel,
  output logic                   err_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_SILENT,
    S_START_REQ,
    S_START_EN,
    S_READY,
    S_STOP_DIS,
    S_STOP_REL
  } state_t;

  state_t                 state, state_next;
  logic [SEL_W-1:0]       cur_sel, cur_sel_next;
  logic [SEL_W-1:0]       pending_sel, pending_sel_next;
  logic                   switch_pending, switch_pending_next;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_next;
  logic                   err_timeout_next, err_bad_sel_next;
  logic                   waiting;
  logic                   sel_in_range;
  logic                   sel_switch;
  logic [NUM_PARENTS-1:0] cur_onehot;
  logic [NUM_PARENTS-1:0] ack_sync [SYNC_STAGES];
  logic [NUM_PARENTS-1:0] ack_synced;

  // Parent start/stop progress is informational only.
  logic status_unused;
  assign status_unused = ^{parent_starting, parent_stopping};

  assign cur_onehot   = NUM_PARENTS'(1) << cur_sel;
  assign sel_in_range = (32'(sel) < NUM_PARENTS);
  assign sel_switch   = sel_valid && sel_in_range && (sel != cur_sel);
  assign ack_synced   = ack_sync[SYNC_STAGES-1];

  // Ack synchronizers: the macro acks are asynchronous to clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) ack_sync[i] <= '0;
    end else begin
      ack_sync[0] <= async_enable_ack;
      for (int i = 1; i < int'(SYNC_STAGES); i++) ack_sync[i] <= ack_sync[i-1];
    end
  end

  // State and control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_SILENT;
      cur_sel        <= SEL_W'(DEFAULT_SEL);
      pending_sel    <= '0;
      switch_pending <= 1'b0;
      wait_cnt       <= '0;
      err_timeout    <= 1'b0;
      err_bad_sel    <= 1'b0;
    end else begin
      state          <= state_next;
      cur_sel        <= cur_sel_next;
      pending_sel    <= pending_sel_next;
      switch_pending <= switch_pending_next;
      wait_cnt       <= wait_cnt_next;
      err_timeout    <= err_timeout_next;
      err_bad_sel    <= err_bad_sel_next;
    end
  end

  // Next state, selection bookkeeping and Moore output decode.
  always_comb begin
    state_next          = state;
    cur_sel_next        = cur_sel;
    pending_sel_next    = pending_sel;
    switch_pending_next = switch_pending;
    err_bad_sel_next    = 1'b0;
    waiting             = 1'b0;
    sel_ready           = 1'b0;
    parent_request      = '0;
    async_enable        = '0;
    child_ready         = 1'b0;
    child_silent        = 1'b0;
    child_starting      = 1'b0;
    child_stopping      = 1'b0;

    case (state)
      S_SILENT: begin
        child_silent = 1'b1;
        sel_ready    = 1'b1;
        if (sel_valid) begin
          if (sel_in_range) cur_sel_next = sel;
          else              err_bad_sel_next = 1'b1;
        end
        if (child_request) state_next = S_START_REQ;
      end
      S_START_REQ: begin
        waiting        = 1'b1;
        parent_request = cur_onehot;
        child_starting = 1'b1;
        if (!child_request)             state_next = S_STOP_REL;
        else if (parent_ready[cur_sel]) state_next = S_START_EN;
      end
      S_START_EN: begin
        waiting        = 1'b1;
        parent_request = cur_onehot;
        async_enable   = cur_onehot;
        child_starting = 1'b1;
        if (!child_request)           state_next = S_STOP_DIS;
        else if (ack_synced[cur_sel]) state_next = S_READY;
      end
      S_READY: begin
        sel_ready      = 1'b1;
        child_ready    = 1'b1;
        parent_request = cur_onehot;
        async_enable   = cur_onehot;
        // Re-selecting the current parent is a no-op; a new one starts a switch.
        if (sel_valid && !sel_in_range) err_bad_sel_next = 1'b1;
        if (sel_switch) begin
          pending_sel_next    = sel;
          switch_pending_next = 1'b1;
        end
        if (!child_request || sel_switch) state_next = S_STOP_DIS;
      end
      S_STOP_DIS: begin
        waiting        = 1'b1;
        parent_request = cur_onehot;
        child_stopping = 1'b1;
        // The old input must be seen disabled before any other input is enabled.
        if (!ack_synced[cur_sel]) state_next = S_STOP_REL;
      end
      S_STOP_REL: begin
        waiting        = 1'b1;
        child_stopping = 1'b1;
        if (parent_silent[cur_sel]) begin
          if (switch_pending) begin
            cur_sel_next        = pending_sel;
            switch_pending_next = 1'b0;
          end
          state_next = (switch_pending && child_request) ? S_START_REQ : S_SILENT;
        end
      end
      default: state_next = S_SILENT;
    endcase

    // Wait counter restarts on every state change and saturates at the limit.
    if (state_next != state)                    wait_cnt_next = '0;
    else if (waiting && (wait_cnt != CNT_MAX))  wait_cnt_next = wait_cnt + CNT_W'(1);
    else                                        wait_cnt_next = wait_cnt;

    err_timeout_next = err_timeout | (waiting && (wait_cnt_next == CNT_MAX));
  end

endmodule
